// File: rtl/alu_pkg.sv
// ============================================================================
// Module      : alu_pkg
// Description : Shared comparator opcodes, branch funct3 codes and resolver
//               FSM states.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_pkg;

    localparam int C_XLEN   = 32;
    localparam int C_PC_INC = 4;

    typedef enum logic [3:0] {
        NOP  = 4'b0000,
        SLT  = 4'b0101,
        SGT  = 4'b0110,
        SLTU = 4'b0111,
        SGTU = 4'b1000,
        EQ   = 4'b1001,
        NE   = 4'b1010
    } cmp_opcode_e;

    typedef enum logic [2:0] {
        F3_BEQ  = 3'b000,
        F3_BNE  = 3'b001,
        F3_BLT  = 3'b100,
        F3_BGE  = 3'b101,
        F3_BLTU = 3'b110,
        F3_BGEU = 3'b111
    } branch_funct3_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        RESP = 2'd2
    } branch_state_e;

endpackage : alu_pkg

`default_nettype wire

// File: rtl/branch_resolver_if.sv
// ============================================================================
// Module      : branch_resolver_if
// Description : Request, comparator and response channels of the branch
//               resolver.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface branch_resolver_if #(
    parameter int XLEN = 32
);
    logic            req_valid;
    logic            req_ready;
    logic [2:0]      req_funct3;
    logic [XLEN-1:0] req_rs1;
    logic [XLEN-1:0] req_rs2;
    logic [XLEN-1:0] req_pc;
    logic [XLEN-1:0] req_imm;
    logic            req_pred_taken;

    logic [XLEN-1:0] cmp_a;
    logic [XLEN-1:0] cmp_b;
    logic [3:0]      cmp_opcode;
    logic            cmp_a_sign;
    logic            cmp_b_sign;
    logic [XLEN-1:0] cmp_result;

    logic            rsp_valid;
    logic            rsp_ready;
    logic            rsp_taken;
    logic [XLEN-1:0] rsp_target;
    logic            rsp_mispredict;
    logic            rsp_illegal;

    modport master (
        output req_valid, req_funct3, req_rs1, req_rs2, req_pc, req_imm, req_pred_taken,
        input  req_ready,
        input  cmp_a, cmp_b, cmp_opcode, cmp_a_sign, cmp_b_sign,
        output cmp_result,
        output rsp_ready,
        input  rsp_valid, rsp_taken, rsp_target, rsp_mispredict, rsp_illegal
    );

    modport slave (
        input  req_valid, req_funct3, req_rs1, req_rs2, req_pc, req_imm, req_pred_taken,
        output req_ready,
        output cmp_a, cmp_b, cmp_opcode, cmp_a_sign, cmp_b_sign,
        input  cmp_result,
        input  rsp_ready,
        output rsp_valid, rsp_taken, rsp_target, rsp_mispredict, rsp_illegal
    );

endinterface : branch_resolver_if

`default_nettype wire

// File: rtl/branch_op_map.sv
// ============================================================================
// Module      : branch_op_map
// Description : Combinational funct3 to comparator opcode/invert/sign decode.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module branch_op_map
    import alu_pkg::*;
(
    input  logic [2:0]  funct3,
    output cmp_opcode_e opcode,
    output logic        invert,
    output logic        is_signed,
    output logic        illegal
);

    // GE forms reuse the LT comparison and flip the result.
    always_comb begin
        opcode    = NOP;
        invert    = 1'b0;
        is_signed = 1'b0;
        illegal   = 1'b0;
        case (funct3)
            F3_BEQ:  opcode = EQ;
            F3_BNE:  opcode = NE;
            F3_BLT:  begin opcode = SLT;  is_signed = 1'b1; end
            F3_BGE:  begin opcode = SLT;  is_signed = 1'b1; invert = 1'b1; end
            F3_BLTU: opcode = SLTU;
            F3_BGEU: begin opcode = SLTU; invert = 1'b1; end
            default: illegal = 1'b1;
        endcase
    end

endmodule : branch_op_map

`default_nettype wire

// File: rtl/branch_resolver.sv
// ============================================================================
// Module      : branch_resolver
// Description : Sequential front end that drives an external comparator and
//               returns branch direction, target and mispredict.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module branch_resolver
    import alu_pkg::*;
#(
    parameter int XLEN        = C_XLEN,
    parameter int CMP_LATENCY = 1,
    parameter int PC_INC      = C_PC_INC
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    branch_resolver_if.slave  bus
);

    localparam int              CNT_W      = 2;
    localparam logic [CNT_W-1:0] C_CNT_LOAD = CNT_W'(CMP_LATENCY - 1);
    localparam logic [XLEN-1:0]  C_INC      = XLEN'(PC_INC);

    branch_state_e    state_q, state_d;
    logic [XLEN-1:0]  rs1_q, rs1_d;
    logic [XLEN-1:0]  rs2_q, rs2_d;
    logic [XLEN-1:0]  pc_q, pc_d;
    logic [XLEN-1:0]  imm_q, imm_d;
    logic             pred_q, pred_d;
    cmp_opcode_e      opcode_q, opcode_d;
    logic             invert_q, invert_d;
    logic             signed_q, signed_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rsp_taken_q, rsp_taken_d;
    logic [XLEN-1:0]  rsp_target_q, rsp_target_d;
    logic             rsp_mispredict_q, rsp_mispredict_d;
    logic             rsp_illegal_q, rsp_illegal_d;

    cmp_opcode_e      w_map_opcode;
    logic             w_map_invert;
    logic             w_map_signed;
    logic             w_map_illegal;
    logic             w_taken;
    logic             w_in_cmp;
    logic             w_unused_result;

    branch_op_map u_op_map (
        .funct3    (bus.req_funct3),
        .opcode    (w_map_opcode),
        .invert    (w_map_invert),
        .is_signed (w_map_signed),
        .illegal   (w_map_illegal)
    );

    // Only bit 0 of the comparator result carries information.
    assign w_unused_result = ^bus.cmp_result[XLEN-1:1];
    assign w_taken         = bus.cmp_result[0] ^ invert_q;
    assign w_in_cmp        = (state_q == CMP);

    always_comb begin
        state_d          = state_q;
        rs1_d            = rs1_q;
        rs2_d            = rs2_q;
        pc_d             = pc_q;
        imm_d            = imm_q;
        pred_d           = pred_q;
        opcode_d         = opcode_q;
        invert_d         = invert_q;
        signed_d         = signed_q;
        cnt_d            = cnt_q;
        rsp_taken_d      = rsp_taken_q;
        rsp_target_d     = rsp_target_q;
        rsp_mispredict_d = rsp_mispredict_q;
        rsp_illegal_d    = rsp_illegal_q;

        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    rs1_d    = bus.req_rs1;
                    rs2_d    = bus.req_rs2;
                    pc_d     = bus.req_pc;
                    imm_d    = bus.req_imm;
                    pred_d   = bus.req_pred_taken;
                    opcode_d = w_map_opcode;
                    invert_d = w_map_invert;
                    signed_d = w_map_signed;
                    cnt_d    = C_CNT_LOAD;
                    // Illegal encodings never touch the comparator.
                    if (w_map_illegal) begin
                        rsp_illegal_d    = 1'b1;
                        rsp_taken_d      = 1'b0;
                        rsp_target_d     = bus.req_pc + C_INC;
                        rsp_mispredict_d = bus.req_pred_taken;
                        state_d          = RESP;
                    end else begin
                        state_d = CMP;
                    end
                end
            end
            CMP: begin
                if (cnt_q == '0) begin
                    rsp_illegal_d    = 1'b0;
                    rsp_taken_d      = w_taken;
                    rsp_target_d     = w_taken ? (pc_q + imm_q) : (pc_q + C_INC);
                    rsp_mispredict_d = w_taken ^ pred_q;
                    state_d          = RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (flush) begin
            state_d          = IDLE;
            cnt_d            = '0;
            rsp_taken_d      = 1'b0;
            rsp_target_d     = '0;
            rsp_mispredict_d = 1'b0;
            rsp_illegal_d    = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q          <= IDLE;
            rs1_q            <= '0;
            rs2_q            <= '0;
            pc_q             <= '0;
            imm_q            <= '0;
            pred_q           <= 1'b0;
            opcode_q         <= NOP;
            invert_q         <= 1'b0;
            signed_q         <= 1'b0;
            cnt_q            <= '0;
            rsp_taken_q      <= 1'b0;
            rsp_target_q     <= '0;
            rsp_mispredict_q <= 1'b0;
            rsp_illegal_q    <= 1'b0;
        end else begin
            state_q          <= state_d;
            rs1_q            <= rs1_d;
            rs2_q            <= rs2_d;
            pc_q             <= pc_d;
            imm_q            <= imm_d;
            pred_q           <= pred_d;
            opcode_q         <= opcode_d;
            invert_q         <= invert_d;
            signed_q         <= signed_d;
            cnt_q            <= cnt_d;
            rsp_taken_q      <= rsp_taken_d;
            rsp_target_q     <= rsp_target_d;
            rsp_mispredict_q <= rsp_mispredict_d;
            rsp_illegal_q    <= rsp_illegal_d;
        end
    end

    // Comparator sees its NOP default whenever no compare is in progress.
    assign bus.cmp_a          = w_in_cmp ? rs1_q : '0;
    assign bus.cmp_b          = w_in_cmp ? rs2_q : '0;
    assign bus.cmp_opcode     = w_in_cmp ? opcode_q : NOP;
    assign bus.cmp_a_sign     = w_in_cmp & signed_q & rs1_q[XLEN-1];
    assign bus.cmp_b_sign     = w_in_cmp & signed_q & rs2_q[XLEN-1];

    assign bus.req_ready      = (state_q == IDLE);
    assign bus.rsp_valid      = (state_q == RESP);
    assign bus.rsp_taken      = rsp_taken_q;
    assign bus.rsp_target     = rsp_target_q;
    assign bus.rsp_mispredict = rsp_mispredict_q;
    assign bus.rsp_illegal    = rsp_illegal_q;

endmodule : branch_resolver

`default_nettype wire

// File: doc/branch_resolver.md
Name: branch_resolver

Overview:
- Sequential front end for the combinational comparator.
- Accepts one RV32I conditional branch at a time over a valid/ready request channel.
- Maps funct3 to a comparator opcode, drives the comparator inputs and waits CMP_LATENCY cycles. It then captures the comparator result and returns taken, target and mispredict over a valid/ready response channel.
- Sits between decode/issue and the PC redirect logic.

Parameters:
- XLEN, 32, operand/PC width; only 32 is supported, matching the comparator.
- CMP_LATENCY, 1, cycles the comparator inputs are held before the result is sampled; range 1..4.
- PC_INC, 4, fall-through increment.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous kill of the in-flight branch.
- req_valid  input  1  request valid.
- req_ready  output  1  request ready.
- req_funct3  input  3  branch funct3.
- req_rs1  input  32  operand A.
- req_rs2  input  32  operand B.
- req_pc  input  32  branch PC.
- req_imm  input  32  sign-extended B-immediate.
- req_pred_taken  input  1  front-end prediction.
- cmp_a  output  32  comparator A.
- cmp_b  output  32  comparator B.
- cmp_opcode  output  4  comparator opcode.
- cmp_a_sign  output  1  comparator A sign.
- cmp_b_sign  output  1  comparator B sign.
- cmp_result  input  32  comparator Result; only bit 0 is used.
- rsp_valid  output  1  response valid.
- rsp_ready  input  1  response ready.
- rsp_taken  output  1  resolved direction.
- rsp_target  output  32  next PC.
- rsp_mispredict  output  1  rsp_taken != captured pred_taken.
- rsp_illegal  output  1  funct3 is 010 or 011.

Behaviour:
- Interface: single clock clk; reset is asynchronous and active-high.
- Reset values:
  - FSM goes to IDLE.
  - req_ready=1 (IDLE).
  - rsp_valid=0, rsp_taken=0, rsp_target=0, rsp_mispredict=0, rsp_illegal=0.
  - cmp_a=0, cmp_b=0, cmp_opcode=4'b0000, cmp_a_sign=0, cmp_b_sign=0.
  - Wait counter=0.
- FSM states: IDLE, CMP, RESP.
  - IDLE: req_ready=1. On req_valid, capture all req_* into registers and go to CMP. Counter loads CMP_LATENCY-1.
  - CMP: req_ready=0. cmp_* are driven from the captured registers. The counter decrements each cycle. When it is 0 that cycle, sample cmp_result[0], compute the response fields and go to RESP.
  - RESP: rsp_valid=1 and all rsp_* are held stable until rsp_ready. On rsp_valid&&rsp_ready, go to IDLE. No same-cycle re-accept: req_ready stays 0 in RESP.
- Latency: request accepted at edge N gives rsp_valid high from cycle N+1+CMP_LATENCY. Minimum occupancy is CMP_LATENCY+2 cycles per branch.
- Opcode map (funct3 → cmp_opcode, invert):
  - 000 BEQ → 1001, no invert.
  - 001 BNE → 1010, no invert.
  - 100 BLT → 0101, no invert.
  - 101 BGE → 0101, invert.
  - 110 BLTU → 0111, no invert.
  - 111 BGEU → 1000 (unsigned greater-than) is not used; BGEU uses 0111 with invert.
- Sign bits: cmp_a_sign=rs1[31] and cmp_b_sign=rs2[31] for signed ops (100, 101); both 0 otherwise.
- Outside CMP, cmp_* are driven 0 and cmp_opcode is 0000 (comparator default, Result=0).
- Illegal funct3 (010, 011): skip CMP and go IDLE→RESP directly. Response is rsp_illegal=1, rsp_taken=0, rsp_target=pc+PC_INC, rsp_mispredict=pred_taken.
- rsp_taken = cmp_result[0] XOR invert.
- rsp_target = taken ? pc+imm : pc+PC_INC. Sums are modulo 2^32; carry is discarded (0xFFFFFFFC+4 = 0).
- rsp_mispredict = rsp_taken XOR captured pred_taken.
- Flush: highest priority after reset. In any state, it forces IDLE next cycle, clears rsp_valid, and zeroes cmp_*. A flush in IDLE coincident with req_valid drops the request (not accepted; req_ready is still 1, and the producer must treat it as killed).
- Reset mid-operation: asynchronous return to reset values; the in-flight branch is lost.
- Backpressure: rsp_ready low holds RESP indefinitely; outputs do not change.

Decomposition:
- Shared package alu_pkg:
  - cmp_opcode_e: SLT=0101, SGT=0110, SLTU=0111, SGTU=1000, EQ=1001, NE=1010, NOP=0000.
  - branch_funct3_e.
  - branch_state_e: IDLE, CMP, RESP.
  - Constant PC_INC.
- Sub-module branch_op_map (combinational): funct3 → {cmp_opcode, invert, is_signed, illegal}. It is reused by the bench scoreboard.
- The comparator itself is instantiated by the parent, not inside this block.

Test Plan:
- BEQ: rs1=rs2=0x1234, pc=0x100, imm=0x20, pred=0, CMP_LATENCY=1 → cmp_opcode=1001 during CMP; rsp_valid at cycle 3; taken=1, target=0x120, mispredict=1.
- BGE signed: rs1=0xFFFFFFFF (-1), rs2=0x1 → opcode 0101, cmp_a_sign=1, cmp_b_sign=0, result=1 → taken=0, target=pc+4.
- BGEU: rs1=0xFFFFFFFF, rs2=0x1 → opcode 0111, both sign bits 0, result=0 → taken=1; pc=0xFFFFFFF0, imm=0x10 → target=0x00000000 (wrap).
- Illegal funct3=011, pred=1 → no CMP cycle; rsp_illegal=1, taken=0, mispredict=1, rsp_valid at cycle 2.
- Backpressure: rsp_ready=0 for 5 cycles → rsp_* are stable, req_ready=0, and a second req_valid is not accepted; after rsp_ready=1, the next request is accepted the cycle after returning to IDLE.
- Flush during CMP with CMP_LATENCY=3, plus async reset asserted mid-RESP → IDLE next cycle, rsp_valid never rises, cmp_opcode=0000; after reset, all outputs are at reset values immediately, without waiting for a clock.
